// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: per-channel synchroniser, bounce filter FSM, level and press/release strobes.
// Optional auto-repeat of btn_press while held is enabled by defining DEBOUNCE_AUTOREPEAT_EN.
module debounce_bank #(
   parameter int CHANNELS      = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int CNT_W         = 20,
   parameter int STABLE_CNT    = 1000000,
   parameter int REPEAT_DELAY  = 5000000,
   parameter int REPEAT_PERIOD = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] btn_level,
   output logic [CHANNELS-1:0] btn_press,
   output logic [CHANNELS-1:0] btn_release
);

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam bit AUTOREPEAT = 1'b1;
`else
   localparam bit AUTOREPEAT = 1'b0;
`endif

   // The counter is shared between stability and repeat timing, so it is
   // widened when the repeat intervals need more bits than CNT_W.
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam int CW      = (AUTOREPEAT && (RPT_W > CNT_W)) ? RPT_W : CNT_W;

   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CNT - 1);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam bit            SHORTCUT    = (STABLE_CNT == 1);

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
`endif

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;
      logic                   s;
      state_t                 state_q;
      logic [CW-1:0]          cnt_q;
      logic                   level_q;
      logic                   press_q;
      logic                   release_q;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      logic                   rpt_q;
`endif

      assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_in[c]};
      assign s      = sync_q[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync_q    <= '0;
            state_q   <= LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rpt_q     <= 1'b0;
`endif
         end else begin
            sync_q    <= sync_d;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
               LOW: begin
                  if (s) begin
                     if (SHORTCUT) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                        rpt_q   <= 1'b0;
`endif
                     end else begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= CNT_ONE;
                     end
                  end
               end
               WAIT_HIGH: begin
                  if (!s) begin
                     state_q <= LOW;
                     cnt_q   <= '0;
                  end else if (cnt_q == STABLE_LAST) begin
                     state_q <= HIGH;
                     cnt_q   <= '0;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                     rpt_q   <= 1'b0;
`endif
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               HIGH: begin
                  if (!s) begin
                     if (SHORTCUT) begin
                        state_q   <= LOW;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                     end else begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= CNT_ONE;
                     end
                  end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
                     // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
                     if (cnt_q == (rpt_q ? PERIOD_LAST : DELAY_LAST)) begin
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        rpt_q   <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                     end
`else
                     cnt_q <= '0;
`endif
                  end
               end
               WAIT_LOW: begin
                  if (s) begin
                     state_q <= HIGH;
                     cnt_q   <= '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                     rpt_q   <= 1'b0;
`endif
                  end else if (cnt_q == STABLE_LAST) begin
                     state_q   <= LOW;
                     cnt_q     <= '0;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_q <= LOW;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
               end
            endcase
         end
      end

      assign btn_level[c]   = level_q;
      assign btn_press[c]   = press_q;
      assign btn_release[c] = release_q;
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank (2 channels, STABLE_CNT=8, 2-flop sync).
module tb_debounce_bank;
   localparam int CH = 2;

   logic          clk;
   logic          rst;
   logic [CH-1:0] btn_in;
   logic [CH-1:0] btn_level;
   logic [CH-1:0] btn_press;
   logic [CH-1:0] btn_release;

   int n_checks = 0;
   int n_errors = 0;

   int press_cnt0   = 0;
   int press_cnt1   = 0;
   int rel_cnt0     = 0;
   int overlap_cnt  = 0;
   int snap;

   debounce_bank #(
      .CHANNELS     (CH),
      .SYNC_STAGES  (2),
      .CNT_W        (8),
      .STABLE_CNT   (8),
      .REPEAT_DELAY (20),
      .REPEAT_PERIOD(5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobes are one cycle wide, so each is seen exactly once at the falling edge.
   always @(negedge clk) begin
      if (btn_press[0])   press_cnt0  <= press_cnt0 + 1;
      if (btn_press[1])   press_cnt1  <= press_cnt1 + 1;
      if (btn_release[0]) rel_cnt0    <= rel_cnt0 + 1;
      if ((btn_press & btn_release) != '0) overlap_cnt <= overlap_cnt + 1;
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [CH-1:0] v, input int n);
      btn_in = v;
      tick(n);
   endtask

   initial begin
      rst    = 1'b0;
      btn_in = '0;
      #23;
      check_val("reset_level",   int'(btn_level),   0);
      check_val("reset_press",   int'(btn_press),   0);
      check_val("reset_release", int'(btn_release), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick(3);

      // Single press on channel 0
      btn_in = 2'b01;
      tick(9);
      check_val("press_e8_level", int'(btn_level), 0);
      check_val("press_e8_press", int'(btn_press), 0);
      tick(1);
      check_val("press_e9_level", int'(btn_level), 1);
      check_val("press_e9_press", int'(btn_press), 1);
      check_val("press_e9_rel",   int'(btn_release), 0);
      tick(1);
      check_val("press_e10_press", int'(btn_press), 0);
      check_val("press_e10_level", int'(btn_level), 1);

      // Release on channel 0
      btn_in = 2'b00;
      tick(9);
      check_val("rel_e8_level", int'(btn_level), 1);
      tick(1);
      check_val("rel_e9_release", int'(btn_release), 1);
      check_val("rel_e9_level",   int'(btn_level), 0);
      check_val("rel_e9_press",   int'(btn_press), 0);
      tick(1);
      check_val("rel_e10_release", int'(btn_release), 0);

      // Short low glitch while high is discarded
      hold(2'b01, 12);
      check_val("glitch_pre_level", int'(btn_level), 1);
      snap = rel_cnt0;
      hold(2'b00, 6);
      hold(2'b01, 15);
      check_val("glitch_level",    int'(btn_level), 1);
      check_val("glitch_releases", rel_cnt0 - snap, 0);
      hold(2'b00, 12);
      check_val("glitch_end_level", int'(btn_level), 0);

      // Bounce with high widths 3, 5, 7 then a steady press
      snap = press_cnt0;
      hold(2'b01, 3);
      hold(2'b00, 2);
      hold(2'b01, 5);
      hold(2'b00, 2);
      hold(2'b01, 7);
      hold(2'b00, 2);
      check_val("bounce_presses", press_cnt0 - snap, 0);
      check_val("bounce_level",   int'(btn_level), 0);
      btn_in = 2'b01;
      tick(9);
      check_val("bounce_e8_press", int'(btn_press), 0);
      tick(1);
      check_val("bounce_e9_press", int'(btn_press), 1);
      tick(1);
      check_val("bounce_total", press_cnt0 - snap, 1);
      hold(2'b00, 12);

      // Both channels on the same edge
      btn_in = 2'b11;
      tick(10);
      check_val("dual_press", int'(btn_press), 3);
      tick(1);
      check_val("dual_press_clear", int'(btn_press), 0);
      check_val("dual_level",       int'(btn_level), 3);
      hold(2'b00, 12);
      check_val("dual_released", int'(btn_level), 0);

      // Asynchronous reset in WAIT_HIGH (count=5), input stays high
      btn_in = 2'b01;
      tick(7);
      #1;
      rst = 1'b0;
      #1;
      check_val("rstwh_level", int'(btn_level), 0);
      check_val("rstwh_press", int'(btn_press), 0);
      tick(1);
      rst = 1'b1;
      tick(9);
      check_val("rstwh_e8_press", int'(btn_press), 0);
      tick(1);
      check_val("rstwh_e9_press", int'(btn_press), 1);
      check_val("rstwh_e9_level", int'(btn_level), 1);
      tick(2);

      // Asynchronous reset while high clears the level without a clock edge
      #1;
      rst = 1'b0;
      #1;
      check_val("rsthi_level", int'(btn_level), 0);
      tick(1);
      rst = 1'b1;
      hold(2'b00, 12);

      // Long hold on channel 1: repeats only with auto-repeat built in
      snap = press_cnt1;
      btn_in = 2'b10;
      tick(10);
      check_val("hold_first_press", int'(btn_press), 2);
      tick(20);
`ifdef DEBOUNCE_AUTOREPEAT_EN
      check_val("hold_e29_press", int'(btn_press), 2);
`else
      check_val("hold_e29_press", int'(btn_press), 0);
`endif
      tick(5);
`ifdef DEBOUNCE_AUTOREPEAT_EN
      check_val("hold_e34_press", int'(btn_press), 2);
`else
      check_val("hold_e34_press", int'(btn_press), 0);
`endif
      tick(25);
      btn_in = 2'b00;
      tick(20);
`ifdef DEBOUNCE_AUTOREPEAT_EN
      check_val("hold_press_count", press_cnt1 - snap, 8);
`else
      check_val("hold_press_count", press_cnt1 - snap, 1);
`endif
      check_val("hold_end_level", int'(btn_level), 0);
      check_val("press_release_overlap", overlap_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
